// File: rtl/alu_issue_queue.sv
// Buffered issue stage for the 32-bit ALU: request FIFO, head drive onto the ALU operand ports,
// and a registered result stage with its own valid/ready handshake toward the consumer.
module alu_issue_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_A,
  input  logic [DATA_WIDTH-1:0] in_B,
  input  logic [2:0]            in_ALUop,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [2:0]            alu_ALUop,
  input  logic [DATA_WIDTH-1:0] alu_Result,
  input  logic                  alu_Overflow,
  input  logic                  alu_CarryOut,
  input  logic                  alu_Zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_Result,
  output logic                  out_Overflow,
  output logic                  out_CarryOut,
  output logic                  out_Zero,
  output logic [2:0]            out_ALUop,
  output logic                  out_illegal,
  output logic [15:0]           done_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW-1:0] PtrOne    = 1;
  localparam logic [PtrW:0]   CntOne    = 1;
  localparam logic [PtrW:0]   FullCount = (PtrW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_a  [DEPTH];
  logic [DATA_WIDTH-1:0] mem_b  [DEPTH];
  logic [2:0]            mem_op [DEPTH];

  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW:0]   count;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic out_fire;
  logic head_illegal;

  assign full  = (count == FullCount);
  assign empty = (count == '0);

  // Gated by resetn so the producer sees no space while reset is held.
  assign in_ready = resetn && !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!out_valid || out_ready);
  assign out_fire = out_valid && out_ready;

  always_comb begin
    alu_A     = '0;
    alu_B     = '0;
    alu_ALUop = 3'b000;
    if (!empty) begin
      alu_A     = mem_a[rd_ptr];
      alu_B     = mem_b[rd_ptr];
      alu_ALUop = mem_op[rd_ptr];
    end
  end

  always_comb begin
    unique case (alu_ALUop)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111: head_illegal = 1'b0;
      default:                                head_illegal = 1'b1;
    endcase
  end

  // Storage needs no reset: entries are only observed while count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]  <= in_A;
      mem_b[wr_ptr]  <= in_B;
      mem_op[wr_ptr] <= in_ALUop;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_valid    <= 1'b0;
      out_Result   <= '0;
      out_Overflow <= 1'b0;
      out_CarryOut <= 1'b0;
      out_Zero     <= 1'b0;
      out_ALUop    <= 3'b000;
      out_illegal  <= 1'b0;
      done_count   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrOne;
      if (pop)  rd_ptr <= rd_ptr + PtrOne;

      case ({push, pop})
        2'b10:   count <= count + CntOne;
        2'b01:   count <= count - CntOne;
        default: count <= count;
      endcase

      if (pop) begin
        out_valid    <= 1'b1;
        out_ALUop    <= alu_ALUop;
        out_illegal  <= head_illegal;
        out_Result   <= head_illegal ? '0 : alu_Result;
        out_Overflow <= !head_illegal && alu_Overflow;
        out_CarryOut <= !head_illegal && alu_CarryOut;
        out_Zero     <= !head_illegal && alu_Zero;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end

      if (out_fire) done_count <= done_count + 16'd1;
    end
  end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Buffered issue stage directly upstream of the 32-bit `alu` (ops AND/OR/ADD/SUB/SLT). It accepts operation requests over a valid/ready handshake into a small FIFO and drives the queue head onto the ALU operand ports. It captures the combinational ALU `Result`/`Overflow`/`CarryOut`/`Zero` into an output register, and presents them downstream over a second valid/ready handshake. This decouples the ALU from producer and consumer stalls.

## Interface
- `DATA_WIDTH`, 32, operand/result width; matches the ALU.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  queue can accept a request.
- `in_A`, `in_B`  in  DATA_WIDTH  operands.
- `in_ALUop`  in  3  operation code.
- `alu_A`, `alu_B`  out  DATA_WIDTH  operands to the ALU.
- `alu_ALUop`  out  3  opcode to the ALU.
- `alu_Result`  in  DATA_WIDTH  ALU result.
- `alu_Overflow`, `alu_CarryOut`, `alu_Zero`  in  1  ALU flags.
- `out_valid`  out  1  captured result present.
- `out_ready`  in  1  consumer accepts.
- `out_Result`  out  DATA_WIDTH  captured result.
- `out_Overflow`, `out_CarryOut`, `out_Zero`  out  1  captured flags.
- `out_ALUop`  out  3  opcode of the captured entry.
- `out_illegal`  out  1  the captured opcode was not one of the five legal codes.
- `done_count`  out  16  number of completed output handshakes; wraps.

## Operation
- Legal opcodes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT. Codes 011, 100 and 101 are illegal.
- FIFO: `DEPTH` entries of {A, B, ALUop}, with write/read pointers of log2(DEPTH) bits plus an occupancy count of log2(DEPTH)+1 bits.
  - Push on `in_valid && in_ready`.
  - `in_ready = !full`. There is no same-cycle pass-through when full, even if a pop occurs.
- Head drive: `alu_A`/`alu_B`/`alu_ALUop` are combinational from the FIFO head.
  - When the FIFO is empty they drive 0/0/000.
- Capture: a pop occurs when the FIFO is non-empty and the output register is free (`!out_valid || out_ready`). On a pop:
  - The output register loads `alu_Result` and the three flags.
  - It loads the head's opcode and sets `out_valid` = 1.
- Illegal opcode at capture: `out_Result` = 0, all three flags = 0, `out_illegal` = 1. The entry is still popped and delivered.
- Output handshake: `out_valid && out_ready` clears `out_valid` unless a new capture happens in the same cycle. `done_count` increments by 1 on every output handshake.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
- Pointer wrap: modulo `DEPTH`, with no lost or duplicated entries.
- Ordering: strict FIFO; results leave in request order.

## Timing
- Reset, while `resetn` = 0:
  - pointers and count = 0; `in_ready` = 0;
  - `out_valid` = 0; `out_Result` = 0; all flags = 0; `out_ALUop` = 000; `out_illegal` = 0; `done_count` = 0;
  - `alu_*` = 0.
- `in_ready` rises combinationally once `resetn` = 1, because count = 0.
- Reset asserted mid-operation: all queued and captured entries are discarded immediately. No `out_valid` is seen after release until a new push.
- Minimum latency: a request accepted at edge k appears at the ALU during cycle k→k+1 and is captured with `out_valid` = 1 after edge k+1.
- Throughput: 1 result per cycle while `out_ready` = 1 and the FIFO is non-empty.
- Backpressure: with `out_ready` = 0 the output register holds stable. The FIFO then fills to `DEPTH`, and `in_ready` = 0 after the push that reaches full.
- Capacity: `DEPTH`+1 requests can be outstanding (FIFO plus output register).
- All outputs except `in_ready` and `alu_*` are registered.

## Test plan
- Single ADD: A=88, B=5, op=010, `out_ready`=1 → `out_valid` one cycle after acceptance, Result=93, Zero=0, `done_count`=1.
- Back-to-back SUB 111−111 then SLT 1555,11111, `out_ready`=1 → results in order:
  - first: Result=0, Zero=1;
  - second: Result=1, `out_ALUop`=111;
  - consecutive cycles, `done_count`=2.
- Backpressure with `out_ready`=0 and DEPTH=4:
  - push 6 ADDs (1+1, 2+2, …) → exactly 5 accepted, `in_ready`=0 after the 4th FIFO push, output held at Result=2.
  - then `out_ready`=1 → results 2, 4, 6, 8, 10 in order.
- Illegal op: push op=011, A=7, B=9 → captured Result=0, flags 0, `out_illegal`=1, `out_ALUop`=011; the next legal op has `out_illegal`=0.
- Wrap and simultaneous push/pop: stream 20 OR requests (A=i, B=0) with `out_ready` toggling every cycle → every i delivered once, in order, `done_count`=20.
- Reset mid-operation: with 3 entries queued and `out_valid`=1, pulse `resetn` low asynchronously between edges → `out_valid`=0 and `done_count`=0 immediately; no stale result appears after release.
